multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Multi-cycle sequencing FSM for the single-issue MIPS core. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK. In each state it drives the control strobes consumed by the instruction-fetch unit, Decoder/register file, ALU and data memory/IO. It also waits on the memory ready handshake, flags illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
MEM_TIMEOUT, 255, maximum cycles spent in MEM waiting for mem_ready before aborting the access.
CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
clock  in  1  system clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-high; forces the FSM into S_RESET.
Instruction  in  32  current instruction, held stable by the fetch unit after ir_write.
zero  in  1  ALU zero flag, valid in EXECUTE.
mem_ready  in  1  data RAM/IO access complete, sampled in MEM.
ir_write  out  1  latch the fetched instruction.
pc_write  out  1  update PC from the source selected by pc_src.
pc_src  out  2  00 = pc+4, 01 = branch target, 10 = jump target, 11 = rs (jr).
RegWrite  out  1  register file write enable.
RegDst  out  1  0 = rt, 1 = rd.
MemtoReg  out  1  1 = write memory/IO data, 0 = write ALU result.
Jal  out  1  write opcplus4 to $31.
ALUSrc  out  1  0 = read_data_2, 1 = Sign_extend.
alu_op  out  2  00 = add, 01 = sub (branch compare), 10 = use funct, 11 = use opcode (I-type).
MemRead  out  1  data memory/IO read request.
MemWrite  out  1  data memory/IO write request.
illegal  out  1  sticky; set on an undecodable opcode.
mem_error  out  1  sticky; set on a MEM timeout.
state  out  3  current state encoding, for debug.
retired  out  CNT_WIDTH  count of completed instructions.

Behaviour:
- States (3-bit): S_RESET=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5.
- Outputs are combinational from the registered state and the opcode/funct fields of Instruction. Every strobe is 0 in S_RESET.
- While reset is high: state=S_RESET, retired=0, illegal=0, mem_error=0, timeout counter=0.
- Reset asserted mid-instruction aborts immediately. There are no partial writes after reset is asserted.
- On the first clock after reset deasserts: S_RESET -> FETCH.
- FETCH:
  - Drives ir_write=1, pc_write=1, pc_src=00.
  - Always moves to DECODE.
- DECODE (opcode = Instruction[31:26]):
  - j: pc_write=1, pc_src=10. Retire and go to FETCH.
  - jal: pc_write=1, pc_src=10. Go to WRITEBACK.
  - Recognised opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi/addiu/slti/sltiu/andi/ori/xori/lui 0010xx-0011xx. All of these go to EXECUTE.
  - Any other opcode: set illegal, do not retire, go to FETCH (treated as a NOP).
- EXECUTE:
  - R-type: ALUSrc=0, alu_op=10.
  - I-type ALU, lw, sw: ALUSrc=1, alu_op=00 (lw/sw) or 11 (ALU ops).
  - beq/bne: alu_op=01. pc_write=1 with pc_src=01 only if taken (beq: zero=1; bne: zero=0). Retire and go to FETCH.
  - jr (R-type, funct 001000): pc_write=1, pc_src=11. Retire and go to FETCH.
  - lw/sw -> MEM. Everything else -> WRITEBACK.
- MEM:
  - lw holds MemRead=1; sw holds MemWrite=1. The strobe stays high until mem_ready=1 is sampled.
  - On mem_ready: lw -> WRITEBACK; sw retires and goes to FETCH.
  - The timeout counter increments each cycle without mem_ready. If it reaches MEM_TIMEOUT: set mem_error, drop the strobe, do not retire, go to FETCH.
  - The counter clears on leaving MEM.
- WRITEBACK:
  - RegWrite=1.
  - RegDst=1 for R-type, 0 otherwise.
  - MemtoReg=1 for lw only.
  - Jal=1 for jal.
  - Retire and go to FETCH.
- Cycle counts: j = 2; beq/bne/jr/jal = 3; R-type/I-type = 4; sw = 4 + wait; lw = 5 + wait.
- retired increments by 1 on each retiring transition and wraps modulo 2^CNT_WIDTH.
- A write to register 0 is still strobed; the register file ignores it.
- illegal and mem_error clear only on reset.

Decomposition:
- Shared package/definitions: opcode and funct constants, state encodings, alu_op and pc_src encodings, ISA_WIDTH. These extend the existing definitions.v.
- Sub-module: mem_wait_timer (counter with clear/enable, flag at MEM_TIMEOUT). It is the only sensible split; the FSM and decode stay in one module.

Test Plan:
- Reset held 3 cycles, then released with Instruction=add $3,$1,$2 (0x00221820) -> states 1,2,3,5; RegWrite=1 and RegDst=1 in WRITEBACK only; retired=1 after 4 cycles.
- lw $4,8($0) (0x8C040008) with mem_ready delayed 3 cycles -> MemRead high for exactly 4 MEM cycles, then WRITEBACK with MemtoReg=1; total 8 cycles.
- beq (0x10220004): with zero=1 -> pc_write=1 and pc_src=01 in EXECUTE; with zero=0 -> no pc_write in EXECUTE; both take 3 cycles.
- jal 0x0C000010 -> pc_src=10 in DECODE; Jal=1 and RegWrite=1 in WRITEBACK; retired +1.
- sw with mem_ready tied 0, MEM_TIMEOUT=4 -> mem_error=1 after 4 MEM cycles, back to FETCH, retired unchanged.
- Opcode 0x3F, then reset asserted during a MEM wait -> illegal=1; reset forces state=0 and all strobes 0 asynchronously, and clears illegal and retired.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS sequencer.
// Opcodes, funct codes, FSM states and datapath select values.
package multicycle_controller_pkg;

    localparam int ISA_WIDTH = 32;

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_JR     = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_SUB    = 2'b01,
        ALU_FUNCT  = 2'b10,
        ALU_OPCODE = 2'b11
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    // addi..lui occupy opcodes 0x08-0x0F
    function automatic logic is_itype_alu(input logic [5:0] op);
        return op[5:3] == 3'b001;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between the sequencer and the fetch/decode/ALU/memory units.
interface multicycle_controller_if
    import multicycle_controller_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) ();

    logic [ISA_WIDTH-1:0] Instruction;
    logic                 zero;
    logic                 mem_ready;
    logic                 ir_write;
    logic                 pc_write;
    logic [1:0]           pc_src;
    logic                 RegWrite;
    logic                 RegDst;
    logic                 MemtoReg;
    logic                 Jal;
    logic                 ALUSrc;
    logic [1:0]           alu_op;
    logic                 MemRead;
    logic                 MemWrite;
    logic                 illegal;
    logic                 mem_error;
    logic [2:0]           state;
    logic [CNT_WIDTH-1:0] retired;

    modport master (
        input  Instruction, zero, mem_ready,
        output ir_write, pc_write, pc_src, RegWrite, RegDst,
               MemtoReg, Jal, ALUSrc, alu_op, MemRead, MemWrite,
               illegal, mem_error, state, retired
    );

    modport slave (
        output Instruction, zero, mem_ready,
        input  ir_write, pc_write, pc_src, RegWrite, RegDst,
               MemtoReg, Jal, ALUSrc, alu_op, MemRead, MemWrite,
               illegal, mem_error, state, retired
    );

endinterface

// File: rtl/multicycle_controller_mem_wait_timer.sv
// Wait-state counter for the MEM phase.
// last_o marks the final cycle allowed before the access is abandoned.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic en_i,
    output logic last_o
);

    localparam int W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = '0;
        if (en_i && !last_o) cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/multicycle_controller.sv
// Five-phase sequencer for the single-issue MIPS core: drives datapath
// strobes per state, waits on memory, flags faults, counts retirements.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    multicycle_controller_if.master bus
);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;
    logic                 illegal_q, illegal_d;
    logic                 mem_error_q, mem_error_d;
    logic                 retire, tmr_en, tmr_last;

    logic [5:0] op, fn;
    logic is_r, is_jr, is_lw, is_sw, is_beq, is_bne;
    logic is_ialu, is_j, is_jal, legal;

    assign op      = bus.Instruction[31:26];
    assign fn      = bus.Instruction[5:0];
    assign is_r    = (op == OP_RTYPE);
    assign is_jr   = is_r && (fn == FN_JR);
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign is_beq  = (op == OP_BEQ);
    assign is_bne  = (op == OP_BNE);
    assign is_ialu = is_itype_alu(op);
    assign is_j    = (op == OP_J);
    assign is_jal  = (op == OP_JAL);
    assign legal   = is_r | is_lw | is_sw | is_beq | is_bne | is_ialu;

    wire unused_instr = ^bus.Instruction[25:6];

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clock  (clock),
        .reset  (reset),
        .en_i   (tmr_en),
        .last_o (tmr_last)
    );

    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        mem_error_d  = mem_error_q;
        retire       = 1'b0;
        tmr_en       = 1'b0;
        bus.ir_write = 1'b0;
        bus.pc_write = 1'b0;
        bus.pc_src   = PC_PLUS4;
        bus.RegWrite = 1'b0;
        bus.RegDst   = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.Jal      = 1'b0;
        bus.ALUSrc   = 1'b0;
        bus.alu_op   = ALU_ADD;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        unique case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                bus.ir_write = 1'b1;
                bus.pc_write = 1'b1;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                unique case (1'b1)
                    is_j: begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = PC_JUMP;
                        retire       = 1'b1;
                        state_d      = S_FETCH;
                    end
                    is_jal: begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = PC_JUMP;
                        state_d      = S_WRITEBACK;
                    end
                    legal:   state_d = S_EXECUTE;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_EXECUTE: begin
                if (is_r) begin
                    bus.alu_op = ALU_FUNCT;
                end else if (is_lw || is_sw) begin
                    bus.ALUSrc = 1'b1;
                end else if (is_ialu) begin
                    bus.ALUSrc = 1'b1;
                    bus.alu_op = ALU_OPCODE;
                end else begin
                    bus.alu_op = ALU_SUB;
                end
                if (is_beq || is_bne) begin
                    // not-taken leaves pc_src at pc+4
                    if (is_beq ? bus.zero : !bus.zero) begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = PC_BRANCH;
                    end
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_jr) begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = PC_JR;
                    retire       = 1'b1;
                    state_d      = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEM: begin
                bus.MemRead  = is_lw;
                bus.MemWrite = is_sw;
                tmr_en       = !bus.mem_ready;
                if (bus.mem_ready) begin
                    retire  = is_sw;
                    state_d = is_lw ? S_WRITEBACK : S_FETCH;
                end else if (tmr_last) begin
                    mem_error_d = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_WRITEBACK: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = is_r;
                bus.MemtoReg = is_lw;
                bus.Jal      = is_jal;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            default: state_d = S_RESET;
        endcase
    end

    assign retired_d = retired_q + CNT_WIDTH'(retire);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_RESET;
            retired_q   <= '0;
            illegal_q   <= 1'b0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            retired_q   <= retired_d;
            illegal_q   <= illegal_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.retired   = retired_q;
    assign bus.illegal   = illegal_q;
    assign bus.mem_error = mem_error_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed table, reset corner
// sequences and random instruction stream against a per-instruction model.
module tb_multicycle_controller;

    localparam int TMO = 4;
    localparam int CW  = 8;

    typedef struct packed {
        logic [2:0] st;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       RegWrite;
        logic       RegDst;
        logic       MemtoReg;
        logic       Jal;
        logic       ALUSrc;
        logic [1:0] alu_op;
        logic       MemRead;
        logic       MemWrite;
    } obs_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        z;
        int          wt;
        bit          tmo;
        int          cycles;
        int          ret;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    multicycle_controller_if #(.CNT_WIDTH(CW)) bus ();

    multicycle_controller #(
        .MEM_TIMEOUT (TMO),
        .CNT_WIDTH   (CW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          errors = 0;
    int          checks = 0;
    obs_t        exp_q[$];
    int          mem_at;
    logic [CW-1:0] m_ret = '0;
    logic        m_ill = 1'b0;
    logic        m_merr = 1'b0;

    function automatic obs_t sample();
        obs_t o;
        o.st       = bus.state;
        o.ir_write = bus.ir_write;
        o.pc_write = bus.pc_write;
        o.pc_src   = bus.pc_src;
        o.RegWrite = bus.RegWrite;
        o.RegDst   = bus.RegDst;
        o.MemtoReg = bus.MemtoReg;
        o.Jal      = bus.Jal;
        o.ALUSrc   = bus.ALUSrc;
        o.alu_op   = bus.alu_op;
        o.MemRead  = bus.MemRead;
        o.MemWrite = bus.MemWrite;
        return o;
    endfunction

    // Expected per-cycle outputs of one instruction, from its class.
    task automatic build(input logic [31:0] ins, input logic z,
                         input int wt, input bit tmo,
                         output bit rt, output bit ill, output bit me);
        logic [5:0] op, fn;
        bit r, jr, lw, sw, br, ia, j, jal, taken;
        int n;
        obs_t o;
        op = ins[31:26];
        fn = ins[5:0];
        r = (op == 6'h00);
        jr = r && (fn == 6'h08);
        lw = (op == 6'h23);
        sw = (op == 6'h2B);
        br = (op == 6'h04) || (op == 6'h05);
        ia = (op >= 6'h08) && (op <= 6'h0F);
        j = (op == 6'h02);
        jal = (op == 6'h03);
        taken = (op == 6'h04) ? z : !z;
        rt = 0; ill = 0; me = 0; mem_at = -1;
        exp_q.delete();
        o = '0; o.st = 3'd1; o.ir_write = 1; o.pc_write = 1;
        exp_q.push_back(o);
        o = '0; o.st = 3'd2;
        if (j || jal) begin o.pc_write = 1; o.pc_src = 2'd2; end
        exp_q.push_back(o);
        if (j) begin rt = 1; return; end
        if (!(jal || r || lw || sw || br || ia)) begin ill = 1; return; end
        if (!jal) begin
            o = '0; o.st = 3'd3;
            o.ALUSrc = lw || sw || ia;
            o.alu_op = r ? 2'd2 : br ? 2'd1 : ia ? 2'd3 : 2'd0;
            if (br && taken) begin o.pc_write = 1; o.pc_src = 2'd1; end
            if (jr) begin o.pc_write = 1; o.pc_src = 2'd3; end
            exp_q.push_back(o);
            if (br || jr) begin rt = 1; return; end
            if (lw || sw) begin
                n = tmo ? TMO : wt + 1;
                for (int k = 0; k < n; k++) begin
                    o = '0; o.st = 3'd4; o.MemRead = lw; o.MemWrite = sw;
                    exp_q.push_back(o);
                end
                if (tmo) begin me = 1; return; end
                mem_at = 3 + wt;
                if (sw) begin rt = 1; return; end
            end
        end
        o = '0; o.st = 3'd5; o.RegWrite = 1; o.RegDst = r;
        o.MemtoReg = lw; o.Jal = jal;
        exp_q.push_back(o);
        rt = 1;
    endtask

    task automatic run(input string nm, input logic [31:0] ins,
                       input logic z, input int wt, input bit tmo,
                       output int cyc);
        bit rt, ill, me, done;
        obs_t a, e;
        build(ins, z, wt, tmo, rt, ill, me);
        cyc = 0;
        done = 0;
        while (!done) begin
            @(negedge clock);
            bus.Instruction = ins;
            bus.zero = z;
            bus.mem_ready = (cyc == mem_at);
            #1;
            a = sample();
            checks++;
            if (cyc >= exp_q.size()) begin
                errors++;
                $display("FAIL %s extra cycle %0d: state=%0d", nm, cyc, a.st);
            end else begin
                e = exp_q[cyc];
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got st=%0d ctl=%b want st=%0d ctl=%b",
                             nm, cyc, a.st, a[13:0], e.st, e[13:0]);
                end
            end
            cyc++;
            @(posedge clock);
            #1;
            if (bus.state == 3'd1) begin
                done = 1;
            end else if (cyc >= 64) begin
                checks++;
                errors++;
                $display("FAIL %s no return to FETCH after %0d cycles", nm, cyc);
                done = 1;
            end
        end
        checks++;
        if (cyc != exp_q.size()) begin
            errors++;
            $display("FAIL %s length: got %0d want %0d", nm, cyc, exp_q.size());
        end
        if (rt) m_ret = m_ret + 1'b1;
        if (ill) m_ill = 1'b1;
        if (me) m_merr = 1'b1;
        checks++;
        if ({bus.retired, bus.illegal, bus.mem_error} !== {m_ret, m_ill, m_merr}) begin
            errors++;
            $display("FAIL %s status: got ret=%0d ill=%b merr=%b want ret=%0d ill=%b merr=%b",
                     nm, bus.retired, bus.illegal, bus.mem_error, m_ret, m_ill, m_merr);
        end
    endtask

    task automatic check_idle(input string nm);
        obs_t a;
        a = sample();
        checks++;
        if (a !== '0 || bus.retired !== '0 || bus.illegal !== 1'b0
            || bus.mem_error !== 1'b0) begin
            errors++;
            $display("FAIL %s: got st=%0d ctl=%b ret=%0d ill=%b merr=%b want all zero",
                     nm, a.st, a[13:0], bus.retired, bus.illegal, bus.mem_error);
        end
    endtask

    vec_t        tbl[13];
    logic [5:0]  op_pool[10];
    logic [CW-1:0] t_ret;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Instruction = 32'h0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;

        tbl[0]  = '{"add",     32'h00221820, 1'b0, 0, 1'b0, 4, 1};
        tbl[1]  = '{"lw_w3",   32'h8C040008, 1'b0, 3, 1'b0, 8, 1};
        tbl[2]  = '{"beq_t",   32'h10220004, 1'b1, 0, 1'b0, 3, 1};
        tbl[3]  = '{"beq_nt",  32'h10220004, 1'b0, 0, 1'b0, 3, 1};
        tbl[4]  = '{"jal",     32'h0C000010, 1'b0, 0, 1'b0, 3, 1};
        tbl[5]  = '{"j",       32'h08000010, 1'b0, 0, 1'b0, 2, 1};
        tbl[6]  = '{"sw_w0",   32'hAC040008, 1'b0, 0, 1'b0, 4, 1};
        tbl[7]  = '{"addi",    32'h20010005, 1'b0, 0, 1'b0, 4, 1};
        tbl[8]  = '{"lui",     32'h3C011234, 1'b1, 0, 1'b0, 4, 1};
        tbl[9]  = '{"jr",      32'h03E00008, 1'b0, 0, 1'b0, 3, 1};
        tbl[10] = '{"bne_t",   32'h14220004, 1'b0, 0, 1'b0, 3, 1};
        tbl[11] = '{"sw_tmo",  32'hAC050004, 1'b0, 0, 1'b1, 3 + TMO, 0};
        tbl[12] = '{"illegal", 32'hFC000000, 1'b0, 0, 1'b0, 2, 0};

        op_pool = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04,
                    6'h05, 6'h0C, 6'h02, 6'h03, 6'h3F};

        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            check_idle("reset_hold");
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_idle("reset_release");

        t_ret = '0;
        for (int i = 0; i < 13; i++) begin
            int cyc;
            run(tbl[i].name, tbl[i].instr, tbl[i].z, tbl[i].wt, tbl[i].tmo, cyc);
            t_ret = t_ret + CW'(tbl[i].ret);
            checks++;
            if (cyc != tbl[i].cycles || bus.retired !== t_ret) begin
                errors++;
                $display("FAIL %s table: got cycles=%0d ret=%0d want cycles=%0d ret=%0d",
                         tbl[i].name, cyc, bus.retired, tbl[i].cycles, t_ret);
            end
        end

        // lw stalled in MEM, reset lands between clock edges
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            bus.Instruction = 32'h8C040008;
            bus.mem_ready = 1'b0;
        end
        #1;
        checks++;
        if (bus.state !== 3'd4 || bus.MemRead !== 1'b1 || bus.illegal !== 1'b1) begin
            errors++;
            $display("FAIL mem_stall: got st=%0d rd=%b ill=%b want st=4 rd=1 ill=1",
                     bus.state, bus.MemRead, bus.illegal);
        end
        #1;
        reset = 1'b1;
        #1;
        check_idle("async_reset");
        @(posedge clock);
        @(posedge clock);
        #1;
        check_idle("reset_held");
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_idle("reset_release2");
        m_ret = '0;
        m_ill = 1'b0;
        m_merr = 1'b0;

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            int k, cyc;
            ins = $urandom();
            k = $urandom_range(0, 10);
            if (k < 10) ins[31:26] = op_pool[k];
            if (k == 1) ins[5:0] = 6'h08;
            run("rnd", ins, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0), cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
